// File: rtl/pipe_pkg.sv
// Shared types and stage-bundle layouts for the elastic pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // EX/MEM bundle, LSB first: ALU result, rd, PC+4, store data, MemtoReg, ctrl
  localparam int unsigned EXMEM_ALU_W   = 32;
  localparam int unsigned EXMEM_RD_W    = 5;
  localparam int unsigned EXMEM_PC4_W   = 32;
  localparam int unsigned EXMEM_DATA_W  = 32;
  localparam int unsigned EXMEM_M2R_W   = 2;
  localparam int unsigned EXMEM_CTRL_W  = 4;

  localparam int unsigned EXMEM_ALU_LSB  = 0;
  localparam int unsigned EXMEM_RD_LSB   = EXMEM_ALU_LSB + EXMEM_ALU_W;
  localparam int unsigned EXMEM_PC4_LSB  = EXMEM_RD_LSB + EXMEM_RD_W;
  localparam int unsigned EXMEM_DATA_LSB = EXMEM_PC4_LSB + EXMEM_PC4_W;
  localparam int unsigned EXMEM_M2R_LSB  = EXMEM_DATA_LSB + EXMEM_DATA_W;
  localparam int unsigned EXMEM_CTRL_LSB = EXMEM_M2R_LSB + EXMEM_M2R_W;
  localparam int unsigned EXMEM_W        = EXMEM_CTRL_LSB + EXMEM_CTRL_W;

  localparam logic [EXMEM_W-1:0] EXMEM_RESET_VAL = EXMEM_W'(32'h4) << EXMEM_PC4_LSB;

  // IF/ID bundle: instruction in the low word, PC+4 in the high word
  localparam int unsigned IFID_W       = 64;
  localparam int unsigned IFID_PC4_LSB = 32;
  localparam logic [IFID_W-1:0] IFID_RESET_VAL = IFID_W'(32'h4) << IFID_PC4_LSB;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      ST_BUSY: state_occ = 2'd1;
      ST_FULL: state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Payload register with load enable and a clear that restores the reset value.
module pipe_skid_reg #(
  parameter int unsigned         DATA_W    = 107,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) q <= RESET_VAL;
    else if (en)       q <= d;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: valid/ready handshake, optional 2-entry skid, flush to bubble.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = EXMEM_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       st_q, st_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;
  logic              in_xfer, out_xfer;
  logic              main_en;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign in_ready  = SKID ? in_ready_q : (~out_valid_q | out_ready);
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;
  assign main_d    = (st_q == ST_FULL) ? skid_q : in_data;

  // Next state and main-register load; flush wins over any transfer
  always_comb begin
    st_d    = st_q;
    main_en = 1'b0;
    case (st_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          st_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer)        main_en = 1'b1;
        else if (out_xfer)              st_d    = ST_EMPTY;
        else if (in_xfer && SKID)       st_d    = ST_FULL;
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_en = 1'b1;
          st_d    = ST_BUSY;
        end
      end
      default: st_d = ST_EMPTY;
    endcase
    if (flush) st_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q        <= ST_EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      st_q        <= st_d;
      out_valid_q <= (st_d != ST_EMPTY);
      occ_q       <= state_occ(st_d);
      in_ready_q  <= (st_d != ST_FULL);
    end
  end

  pipe_skid_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic skid_en;
      assign skid_en = (st_q == ST_BUSY) & in_xfer & ~out_xfer;
      pipe_skid_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
      );
    end else begin : g_noskid
      assign skid_q = RESET_VAL;
    end
  endgenerate

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !((st_q == ST_FULL) && in_valid && in_ready));
  a_occ_match: assert property (@(posedge clk) disable iff (!reset)
    occupancy == (2'({1'b0, out_valid}) + 2'({1'b0, (st_q == ST_FULL)})));
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomized handshake checks for pipe_stage_elastic, SKID=1 and SKID=0 builds.
module tb_pipe_stage_elastic;

  localparam int unsigned DW    = 8;
  localparam logic [DW-1:0] RV  = 8'hE4;
  localparam int unsigned BEATS = 2000;

  logic clk = 1'b0;
  logic reset, flush;
  logic iv_a, ir_a, ov_a, or_a;
  logic [DW-1:0] id_a, od_a;
  logic [1:0] occ_a;
  logic iv_b, ir_b, ov_b, or_b;
  logic [DW-1:0] id_b, od_b;
  logic [1:0] occ_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .occupancy(occ_a)
  );

  pipe_stage_elastic #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .occupancy(occ_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int sent_a, sent_b, rcv_a, rcv_b;
  logic xa_in, xa_out, xb_in, xb_out;

  initial begin
    reset = 1'b0; flush = 1'b0;
    iv_a = 1'b1; id_a = 8'h5A; or_a = 1'b0;
    iv_b = 1'b0; id_b = 8'h00; or_b = 1'b0;

    // reset held two cycles with a beat offered
    tick(); tick();
    check_eq("rst_ov",  32'(ov_a),  32'd0);
    check_eq("rst_occ", 32'(occ_a), 32'd0);
    check_eq("rst_od",  32'(od_a),  32'(RV));
    iv_a = 1'b0; reset = 1'b1;
    tick();
    check_eq("rst_ir", 32'(ir_a), 32'd1);
    check_eq("rst_ov2", 32'(ov_a), 32'd0);

    // streaming at full throughput
    or_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iv_a = 1'b1; id_a = 8'(i);
      tick();
      check_eq("str_od",  32'(od_a),  32'(i));
      check_eq("str_ov",  32'(ov_a),  32'd1);
      check_eq("str_occ", 32'(occ_a), 32'd1);
    end
    iv_a = 1'b0;
    tick();
    check_eq("str_drain_ov", 32'(ov_a), 32'd0);

    // stall into the skid entry
    or_a = 1'b0;
    iv_a = 1'b1; id_a = 8'h0A; tick();
    check_eq("stl_ir1", 32'(ir_a), 32'd1);
    id_a = 8'h0B; tick();
    iv_a = 1'b0;
    check_eq("stl_occ", 32'(occ_a), 32'd2);
    check_eq("stl_ir0", 32'(ir_a),  32'd0);
    check_eq("stl_od1", 32'(od_a),  32'h0A);
    tick(); check_eq("stl_od2", 32'(od_a), 32'h0A);
    tick(); check_eq("stl_od3", 32'(od_a), 32'h0A);
    or_a = 1'b1;
    tick();
    check_eq("stl_odB",  32'(od_a),  32'h0B);
    check_eq("stl_occ1", 32'(occ_a), 32'd1);
    check_eq("stl_ir",   32'(ir_a),  32'd1);
    tick();
    check_eq("stl_ov0",  32'(ov_a),  32'd0);
    check_eq("stl_occ0", 32'(occ_a), 32'd0);
    or_a = 1'b0;

    // flush while full, with a beat offered that must vanish
    iv_a = 1'b1; id_a = 8'h0A; tick();
    id_a = 8'h0B; tick();
    check_eq("fl_pre_occ", 32'(occ_a), 32'd2);
    id_a = 8'h0C; flush = 1'b1; tick();
    flush = 1'b0; iv_a = 1'b0;
    check_eq("fl_ov",  32'(ov_a),  32'd0);
    check_eq("fl_occ", 32'(occ_a), 32'd0);
    check_eq("fl_od",  32'(od_a),  32'(RV));
    check_eq("fl_ir",  32'(ir_a),  32'd1);
    or_a = 1'b1;
    tick(); check_eq("fl_noC1", 32'(ov_a), 32'd0);
    tick(); check_eq("fl_noC2", 32'(ov_a), 32'd0);
    or_a = 1'b0;

    // flush and reset together
    iv_a = 1'b1; id_a = 8'h33; tick();
    iv_a = 1'b0;
    check_eq("fr_pre_od", 32'(od_a), 32'h33);
    flush = 1'b1; reset = 1'b0; tick();
    check_eq("fr_od",  32'(od_a),  32'(RV));
    check_eq("fr_occ", 32'(occ_a), 32'd0);
    check_eq("fr_ov",  32'(ov_a),  32'd0);
    flush = 1'b0; reset = 1'b1; tick();
    check_eq("fr_ir", 32'(ir_a), 32'd1);

    // SKID=0: in_ready follows out_ready combinationally
    iv_b = 1'b1; id_b = 8'h77; or_b = 1'b0; #1;
    check_eq("s0_ir_empty", 32'(ir_b), 32'd1);
    tick();
    iv_b = 1'b0;
    check_eq("s0_ov", 32'(ov_b), 32'd1);
    check_eq("s0_od", 32'(od_b), 32'h77);
    #1; check_eq("s0_ir_stall", 32'(ir_b), 32'd0);
    or_b = 1'b1;
    #1; check_eq("s0_ir_go", 32'(ir_b), 32'd1);
    tick();
    check_eq("s0_ov0", 32'(ov_b), 32'd0);
    or_b = 1'b0;

    // random valid/ready on both builds against a FIFO scoreboard
    reset = 1'b0; tick(); reset = 1'b1;
    sent_a = 0; sent_b = 0; rcv_a = 0; rcv_b = 0;
    iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      check_eq("rnd_a_occ", 32'(occ_a), 32'(qa.size()));
      check_eq("rnd_b_occ", 32'(occ_b), 32'(qb.size()));
      xa_out = ov_a & or_a; xa_in = iv_a & ir_a;
      xb_out = ov_b & or_b; xb_in = iv_b & ir_b;
      if (xa_out) begin
        if (qa.size() == 0) check_eq("rnd_a_extra", 32'd0, 32'd1);
        else begin
          check_eq("rnd_a_data", 32'(od_a), 32'(qa.pop_front()));
          rcv_a++;
        end
      end
      if (xb_out) begin
        if (qb.size() == 0) check_eq("rnd_b_extra", 32'd0, 32'd1);
        else begin
          check_eq("rnd_b_data", 32'(od_b), 32'(qb.pop_front()));
          rcv_b++;
        end
      end
      if (xa_in) begin qa.push_back(id_a); sent_a++; end
      if (xb_in) begin qb.push_back(id_b); sent_b++; end
      @(posedge clk); #1;
      if (!iv_a || xa_in) begin
        iv_a = (sent_a < BEATS) && ($urandom_range(0, 3) != 0);
        id_a = 8'(sent_a * 13 + 5);
      end
      if (!iv_b || xb_in) begin
        iv_b = (sent_b < BEATS) && ($urandom_range(0, 3) != 0);
        id_b = 8'(sent_b * 11 + 9);
      end
      or_a = ($urandom_range(0, 2) != 0);
      or_b = ($urandom_range(0, 2) != 0);
    end
    check_eq("rnd_a_sent", 32'(sent_a), 32'(BEATS));
    check_eq("rnd_a_rcv",  32'(rcv_a),  32'(BEATS));
    check_eq("rnd_b_sent", 32'(sent_b), 32'(BEATS));
    check_eq("rnd_b_rcv",  32'(rcv_b),  32'(BEATS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
